// File: rtl/lfsr_rand_server.sv
// lfsr_rand_server: one shared 32-bit pseudo-random generator, handed out one
//   value per cycle to NUM_REQ requesters through a round-robin arbiter.
// Latency: zero cycles; grant and rand_o are combinational from registered state and req.
// Backpressure: a requester holds req until granted; no grant during warm-up or in a reseed cycle.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (loads seed_i, restarts warm-up, clears ptr)
//   seed_i       seed value, sampled on rst or reseed_req
//   reseed_req   single-cycle pulse: reload seed and redo warm-up
//   req          per-requester request, held high until granted
//   grant        one-hot grant (zero when nothing is granted)
//   rand_o       current generator value, consumed by the granted requester
//   ready        high while the generator is in RUN
//   grant_count  total grants issued; built only when LFSR_RAND_GRANT_COUNT_EN
//                is defined, otherwise tied to zero
module lfsr_rand_server #(
  parameter int NUM_REQ       = 4,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        seed_i,
  input  logic               reseed_req,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [31:0]        rand_o,
  output logic               ready,
  output logic [31:0]        grant_count
);

  localparam int              PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int              SUM_W    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [7:0]      WARM_LAST = 8'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  // With no warm-up configured, a seed load goes straight to RUN.
  localparam state_t START = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

  state_t           state_q, state_d;
  logic [31:0]      r_q, r_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic             found;
  logic [PTR_W-1:0] win;
  logic [SUM_W-1:0] pos;
  logic             grant_any;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {~(v[31] ^ v[29] ^ v[28]), v[31:1]};
  endfunction

  // Round-robin search: first set request at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_q} + SUM_W'(k);
      if (pos >= SUM_W'(NUM_REQ)) begin
        pos = pos - SUM_W'(NUM_REQ);
      end
      if (!found && req[pos[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = pos[PTR_W-1:0];
      end
    end
  end

  // Outputs. A reseed pulse takes the cycle away from the requesters.
  always_comb begin
    grant = '0;
    if (state_q == RUN && !reseed_req && found) begin
      grant[win] = 1'b1;
    end
  end

  assign grant_any = (state_q == RUN) && !reseed_req && found;
  assign ready     = (state_q == RUN);
  assign rand_o    = r_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (reseed_req) begin
      // ptr deliberately kept so a reseed does not reset fairness.
      r_d     = seed_i;
      cnt_d   = '0;
      state_d = START;
    end else begin
      case (state_q)
        WARMUP: begin
          r_d = lfsr_step(r_q);
          if (cnt_q == WARM_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RUN: begin
          if (grant_any) begin
            r_d   = lfsr_step(r_q);
            ptr_d = (win == PTR_LAST) ? '0 : win + 1'b1;
          end
        end
        default: state_d = START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START;
      r_q     <= seed_i;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef LFSR_RAND_GRANT_COUNT_EN
  // Survives reseed; only rst clears it. Wraps naturally at 2^32.
  logic [31:0] gcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_q <= '0;
    end else if (grant_any) begin
      gcnt_q <= gcnt_q + 32'd1;
    end
  end

  assign grant_count = gcnt_q;
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Bench for lfsr_rand_server: two instances (no warm-up and 3-cycle warm-up)
// share one stimulus stream and are checked every cycle against a model.
module tb_lfsr_rand_server;

  localparam int N = 4;

`ifdef LFSR_RAND_GRANT_COUNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   seed;
  logic          reseed;
  logic [N-1:0]  req;

  logic [N-1:0]  grant_w [2];
  logic [31:0]   rand_w  [2];
  logic          ready_w [2];
  logic [31:0]   gc_w    [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_rand_server #(.NUM_REQ(N), .WARMUP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .seed_i(seed), .reseed_req(reseed), .req(req),
    .grant(grant_w[0]), .rand_o(rand_w[0]), .ready(ready_w[0]), .grant_count(gc_w[0])
  );

  lfsr_rand_server #(.NUM_REQ(N), .WARMUP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .seed_i(seed), .reseed_req(reseed), .req(req),
    .grant(grant_w[1]), .rand_o(rand_w[1]), .ready(ready_w[1]), .grant_count(gc_w[1])
  );

  // ---------------- behavioural model ----------------
  // m_left = warm-up steps still owed; the generator is usable when it is 0.
  logic [31:0] m_r    [2];
  int          m_left [2];
  int          m_ptr  [2];
  logic [31:0] m_gc   [2];
  bit          m_valid = 1'b0;

  function automatic int wu(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Galois-free shift: new MSB = NOT of taps 31, 29, 28, everything else moves down.
  function automatic logic [31:0] nxt(input logic [31:0] v);
    logic fb;
    fb = 1'b1 ^ v[31] ^ v[29] ^ v[28];
    return (v >> 1) | ({31'd0, fb} << 31);
  endfunction

  function automatic int winner(input int k);
    logic [1:0] ii;
    for (int j = 0; j < N; j++) begin
      ii = 2'((m_ptr[k] + j) % N);
      if (req[ii]) return int'(ii);
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant(input int k);
    int w;
    w = winner(k);
    if (m_left[k] == 0 && !reseed && w >= 0) return N'(1) << w;
    return '0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_r[k]    <= seed;
        m_left[k] <= wu(k);
        m_ptr[k]  <= 0;
        m_gc[k]   <= '0;
      end
      m_valid <= 1'b1;
    end else if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        if (reseed) begin
          m_r[k]    <= seed;
          m_left[k] <= wu(k);
        end else if (m_left[k] > 0) begin
          m_r[k]    <= nxt(m_r[k]);
          m_left[k] <= m_left[k] - 1;
        end else if (winner(k) >= 0) begin
          m_r[k]   <= nxt(m_r[k]);
          m_ptr[k] <= (winner(k) + 1) % N;
          m_gc[k]  <= m_gc[k] + 32'd1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk("ready", k, 32'(ready_w[k]), 32'(m_left[k] == 0));
        chk("grant", k, 32'(grant_w[k]), 32'(exp_grant(k)));
        chk("rand_o", k, rand_w[k], m_r[k]);
        chk("grant_count", k, gc_w[k], GC_EN ? m_gc[k] : 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] lit [4];
  logic [N-1:0] rr [5];

  initial begin
    lit = '{32'h0000_0000, 32'h8000_0000, 32'h4000_0000, 32'hA000_0000};
    rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; reseed = 1'b0; req = '0; seed = '0;
    tick();

    // Seed 0, single requester: fixed value sequence; dut1 warms up for 3 cycles.
    rst = 1'b0; req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      at_neg();
      chk("lit_ready0", 0, 32'(ready_w[0]), 32'd1);
      chk("lit_grant0", 0, 32'(grant_w[0]), 32'd1);
      chk("lit_rand0", 0, rand_w[0], lit[c]);
      if (c < 3) begin
        chk("lit_warm_ready1", 1, 32'(ready_w[1]), 32'd0);
        chk("lit_warm_grant1", 1, 32'(grant_w[1]), 32'd0);
      end else begin
        chk("lit_first_grant1", 1, 32'(grant_w[1]), 32'd1);
        chk("lit_first_rand1", 1, rand_w[1], 32'hA000_0000);
      end
      tick();
    end
    // Reseed with r=0xD0000000: grant suppressed, then seed value served.
    reseed = 1'b1; seed = '0;
    at_neg();
    chk("lit_reseed_grant0", 0, 32'(grant_w[0]), 32'd0);
    chk("lit_reseed_rand0", 0, rand_w[0], 32'hD000_0000);
    tick();
    reseed = 1'b0;
    at_neg();
    chk("lit_post_reseed_grant0", 0, 32'(grant_w[0]), 32'd1);
    chk("lit_post_reseed_rand0", 0, rand_w[0], 32'h0000_0000);
    tick();

    // Round-robin order.
    rst = 1'b1; req = '0; tick();
    rst = 1'b0; req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      at_neg();
      chk("lit_rr_all", 0, 32'(grant_w[0]), 32'(rr[c]));
      tick();
    end
    rst = 1'b1; req = '0; tick();
    rst = 1'b0; req = 4'b1010;
    at_neg(); chk("lit_rr_1010a", 0, 32'(grant_w[0]), 32'h2); tick();
    at_neg(); chk("lit_rr_1010b", 0, 32'(grant_w[0]), 32'h8); tick();

    // Reset in the middle of warm-up (cnt=2): full warm-up again.
    rst = 1'b1; seed = '0; req = 4'b0001; tick();
    rst = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      at_neg();
      if (c == 0) chk("lit_rst_seed1", 1, rand_w[1], 32'h0000_0000);
      chk("lit_rst_count1", 1, gc_w[1], 32'd0);
      if (c < 3) chk("lit_rst_ready1", 1, 32'(ready_w[1]), 32'd0);
      else       chk("lit_rst_rand1", 1, rand_w[1], 32'hA000_0000);
      tick();
    end

    // 5 grants, reseed, 2 grants.
    rst = 1'b1; req = '0; tick();
    rst = 1'b0; req = 4'b0001;
    repeat (5) tick();
    reseed = 1'b1; tick();
    reseed = 1'b0; repeat (2) tick();
    req = '0;
    at_neg();
    chk("lit_grant_count7", 0, gc_w[0], GC_EN ? 32'd7 : 32'd0);
    tick();

    // Randomized traffic with occasional reseeds and resets.
    repeat (3000) begin
      rst    = ($urandom_range(0, 63) == 0);
      reseed = ($urandom_range(0, 15) == 0);
      req    = N'($urandom);
      seed   = $urandom;
      tick();
    end
    rst = 1'b0; reseed = 1'b0; req = '0;
    at_neg();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
